// File: rtl/dec_seq_pkg.sv
// dec_seq_pkg: shared state encoding and sizing helpers for the decode/scan sequencer.
package dec_seq_pkg;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    // Bit pos of the one-hot code for index sel.
    function automatic logic onehot(input int unsigned sel, input int unsigned pos);
        return sel == pos;
    endfunction

    function automatic int cnt_width(input int dwell);
        return ($clog2(dwell) < 1) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational N-to-2^N one-hot decoder with enable.
module onehot_dec
    import dec_seq_pkg::*;
#(
    parameter int N = 2
) (
    input  logic            en,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y
);

    for (genvar i = 0; i < 2**N; i++) begin : g_bit
        assign y[i] = en && onehot(32'(sel), i);
    end

endmodule

// File: rtl/dec_n_scan_sequencer.sv
// dec_n_scan_sequencer: registered one-hot decoder with auto-scan of all outputs
// and a valid/ready index load port.
module dec_n_scan_sequencer
    import dec_seq_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            w_valid,
    input  logic [N-1:0]    w,
    output logic            w_ready,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int OUTS = 2**N;
    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    state_t          state, nxt_st;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic [N-1:0]    nxt_idx;
    logic [OUTS-1:0] nxt_y;
    logic            hs, scanning, expire, nxt_wrap;

    assign w_ready = en;
    assign hs = w_valid && en;

    // Counting only continues while already in SCAN; entering SCAN restarts the dwell.
    always_comb begin
        nxt_st   = !en ? IDLE : (mode ? SCAN : DIRECT);
        scanning = nxt_st == SCAN && state == SCAN && !hs;
        expire   = scanning && cnt == LAST;
        nxt_idx  = hs ? w : (expire ? idx + 1'b1 : idx);
        nxt_cnt  = (scanning && !expire) ? cnt + 1'b1 : '0;
        nxt_wrap = expire && idx == '1;
    end

    onehot_dec #(.N(N)) u_dec (
        .en  (nxt_st != IDLE),
        .sel (nxt_idx),
        .y   (nxt_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            y     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= nxt_st;
            cnt   <= nxt_cnt;
            idx   <= nxt_idx;
            y     <= nxt_y;
            wrap  <= nxt_wrap;
        end
    end

endmodule
